// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel pipeline.
package vga_pkg;

  localparam int H_VIS   = 640;
  localparam int V_VIS   = 480;
  localparam int BAR_PIX = 80;
  localparam int COLOR_W = 4;

  typedef enum logic [1:0] {
    PAT_BARS,
    PAT_CHECK,
    PAT_GRAD,
    PAT_MBAR
  } pattern_t;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  // Expand a single on/off flag into a full-scale or zero channel value.
  function automatic logic [COLOR_W-1:0] chan(input logic on);
    return on ? '1 : '0;
  endfunction

endpackage

// File: rtl/vga_pattern_rom.sv
// Combinational stage-1 colour lookup: pattern, pixel position and bar
// position in, raw (unblanked) colour out.
module vga_pattern_rom
  import vga_pkg::*;
#(
  parameter int BAR_W = 16
) (
  input  pattern_t   mode,
  input  logic [9:0] xCor,
  input  logic       yCor5,
  input  logic [9:0] barPos,
  output rgb_t       rgb
);

  logic [9:0]  barIdx;
  logic        barValid;
  logic [10:0] xWide;
  logic [10:0] barLo;
  logic [10:0] barHi;
  logic        inBar;

  // Columns 640..799 give indices 8 and 9; they are blanked downstream,
  // so they simply fall into black here.
  assign barIdx   = xCor / 10'(BAR_PIX);
  assign barValid = (barIdx < 10'd8);

  // 11-bit compare keeps barPos+BAR_W from wrapping near the right edge.
  assign xWide = {1'b0, xCor};
  assign barLo = {1'b0, barPos};
  assign barHi = barLo + 11'(BAR_W);
  assign inBar = (xWide >= barLo) && (xWide < barHi);

  // Select the raw colour for the current pattern.
  always_comb begin
    rgb = '0;
    case (mode)
      PAT_BARS: begin
        rgb.r = chan(barValid && (barIdx inside {10'd0, 10'd1, 10'd4, 10'd5}));
        rgb.g = chan(barIdx < 10'd4);
        rgb.b = chan(barValid && !barIdx[0]);
      end
      PAT_CHECK: begin
        rgb.r = chan(xCor[5] ^ yCor5);
        rgb.g = chan(xCor[5] ^ yCor5);
        rgb.b = chan(xCor[5] ^ yCor5);
      end
      PAT_GRAD: begin
        rgb.r = COLOR_W'(xCor[9:6]);
        rgb.g = COLOR_W'(xCor[9:6]);
        rgb.b = COLOR_W'(xCor[9:6]);
      end
      PAT_MBAR: begin
        if (inBar) begin
          rgb.r = '1;
          rgb.g = '1;
          rgb.b = '1;
        end else begin
          rgb.r = '0;
          rgb.g = '0;
          rgb.b = COLOR_W'(4'h4);
        end
      end
      default: rgb = '0;
    endcase
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator behind the VGA timing generator. Two register
// stages carry colour and sync together so they leave aligned; pattern and
// bar position only change at pixel (0,0) so a frame never tears.
module vga_pattern_gen #(
  parameter int COLOR_W   = 4,
  parameter int BAR_SPEED = 4,
  parameter int BAR_W     = 16
) (
  input  logic               pixelClk,
  input  logic               locked,
  input  logic               hClk,
  input  logic               hVis,
  input  logic               vClk,
  input  logic               vVis,
  input  logic [9:0]         xCor,
  input  logic [9:0]         yCor,
  input  logic [1:0]         modeSel,
  output logic [COLOR_W-1:0] vgaR,
  output logic [COLOR_W-1:0] vgaG,
  output logic [COLOR_W-1:0] vgaB,
  output logic               hSync,
  output logic               vSync,
  output logic               frameStart
);

  import vga_pkg::*;

  logic        fs;
  pattern_t    modeReg;
  pattern_t    modeCur;
  logic [9:0]  barPos;
  logic [10:0] barSum;
  logic [9:0]  barNext;
  logic [9:0]  barCur;
  rgb_t        rawRgb;

  rgb_t        s1Rgb;
  logic        s1Vis;
  logic        s1HSync;
  logic        s1VSync;
  logic        s1Fs;

  assign fs = (xCor == 10'd0) && (yCor == 10'd0);

  assign barSum  = {1'b0, barPos} + 11'(BAR_SPEED);
  assign barNext = (barSum >= 11'(H_VIS)) ? 10'd0 : barSum[9:0];

  // On the frame-start pixel itself the fresh mode and bar position are
  // forwarded, so pixel (0,0) already belongs to the new frame.
  assign modeCur = fs ? pattern_t'(modeSel) : modeReg;
  assign barCur  = fs ? barNext : barPos;

  vga_pattern_rom #(
    .BAR_W (BAR_W)
  ) uRom (
    .mode   (modeCur),
    .xCor   (xCor),
    .yCor5  (yCor[5]),
    .barPos (barCur),
    .rgb    (rawRgb)
  );

  // Per-frame state: latch the requested mode and advance the bar at (0,0).
  always_ff @(posedge pixelClk) begin
    if (!locked) begin
      modeReg <= PAT_BARS;
      barPos  <= 10'd0;
    end else if (fs) begin
      modeReg <= pattern_t'(modeSel);
      barPos  <= barNext;
    end
  end

  // Stage 1: register raw colour with its visibility, sync and frame flag.
  always_ff @(posedge pixelClk) begin
    if (!locked) begin
      s1Rgb   <= '0;
      s1Vis   <= 1'b0;
      s1HSync <= 1'b1;
      s1VSync <= 1'b1;
      s1Fs    <= 1'b0;
    end else begin
      s1Rgb   <= rawRgb;
      s1Vis   <= hVis & vVis;
      s1HSync <= hClk;
      s1VSync <= vClk;
      s1Fs    <= fs;
    end
  end

  // Stage 2: blank outside the visible window and drive the connector.
  always_ff @(posedge pixelClk) begin
    if (!locked) begin
      vgaR       <= '0;
      vgaG       <= '0;
      vgaB       <= '0;
      hSync      <= 1'b1;
      vSync      <= 1'b1;
      frameStart <= 1'b0;
    end else begin
      vgaR       <= s1Vis ? COLOR_W'(s1Rgb.r) : '0;
      vgaG       <= s1Vis ? COLOR_W'(s1Rgb.g) : '0;
      vgaB       <= s1Vis ? COLOR_W'(s1Rgb.b) : '0;
      hSync      <= s1HSync;
      vSync      <= s1VSync;
      frameStart <= s1Fs;
    end
  end

endmodule
